// File: rtl/mult_pkg.sv
// Shared widths and types for the 4x4 multiplier and the dot-product stage built on it.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_pkg;

   localparam int OPW   = 4;   // operand width
   localparam int PRODW = 8;   // full product width of an OPW x OPW multiply

   // Accumulation FSM: collect products, let the closing product land, present result.
   typedef enum logic [1:0] {
      ACC   = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } acc_state_e;

endpackage

// File: rtl/mult4_dot_s1.sv
// S1 operand register plus the multiplier that reads it; product is combinational off the flops.
// Latency: 1 cycle from accept to s1_vld / prod.
// Backpressure: none; the downstream accumulator consumes every cycle, so S1 never stalls.
//   acpt    : load a_in/b_in/last_in this cycle     s1_vld : registered pair is new this cycle
//   s1_last : registered last flag                  prod   : a_q * b_q
module mult4_dot_s1
   import mult_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             acpt,
   input  logic [OPW-1:0]   a_in,
   input  logic [OPW-1:0]   b_in,
   input  logic             last_in,
   output logic             s1_vld,
   output logic             s1_last,
   output logic [PRODW-1:0] prod
);

   logic [OPW-1:0] a_q, a_d;
   logic [OPW-1:0] b_q, b_d;
   logic           last_q, last_d;
   logic           vld_q, vld_d;

   always_comb begin
      vld_d  = acpt;
      a_d    = acpt ? a_in    : a_q;
      b_d    = acpt ? b_in    : b_q;
      last_d = acpt ? last_in : last_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         last_q <= 1'b0;
      end else begin
         vld_q  <= vld_d;
         a_q    <= a_d;
         b_q    <= b_d;
         last_q <= last_d;
      end
   end

   mult4x4 u_mult (
      .a (a_q),
      .b (b_q),
      .p (prod)
   );

   assign s1_vld  = vld_q;
   assign s1_last = last_q;

endmodule

// File: rtl/mult4x4.sv
// Combinational 4x4 unsigned multiplier.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
//   a, b : operands        p : full 8-bit product
module mult4x4
   import mult_pkg::*;
(
   input  logic [OPW-1:0]   a,
   input  logic [OPW-1:0]   b,
   output logic [PRODW-1:0] p
);

   assign p = PRODW'(a) * PRODW'(b);

endmodule

// File: rtl/mult4_dot_accum.sv
// Dot-product MAC: accumulates a*b over a vector closed by in_last or the length limit.
// Latency: closing pair accepted at edge t -> out_valid after edge t+2.
// Backpressure: in_ready drops from closing accept until the result handshake; out_* held while stalled.
//   in_valid/in_ready/in_a/in_b/in_last : operand stream
//   out_valid/out_ready/out_sum/out_len/out_ovf/out_trunc : one result per vector
module mult4_dot_accum
   import mult_pkg::*;
#(
   parameter int ACC_W = 16,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   in_a,
   input  logic [OPW-1:0]   in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [LEN_W:0]   out_len,
   output logic             out_ovf,
   output logic             out_trunc
);

   // Result widths track the instance parameters.
   typedef struct packed {
      logic [ACC_W-1:0] sum;
      logic [LEN_W:0]   len;
      logic             ovf;
      logic             trunc;
   } res_t;

   localparam logic [LEN_W:0] ONE   = (LEN_W+1)'(1);
   localparam logic [LEN_W:0] LIMIT = ONE << LEN_W;

   acc_state_e       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [LEN_W:0]   cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             trunc_q, trunc_d;
   res_t             res_q, res_d;
   logic             out_vld_q, out_vld_d;

   logic             accept;
   logic             closing;
   logic             s1_vld;
   logic             s1_last;
   logic [PRODW-1:0] prod;
   logic [ACC_W-1:0] add_val;
   logic [ACC_W:0]   acc_sum;
   logic [LEN_W:0]   cnt_inc;
   logic [LEN_W:0]   pend;

   // Gated with rst_n so in_ready reads 0 for the whole reset window.
   assign in_ready = rst_n & (state_q == ACC);
   assign accept   = in_valid & in_ready;

   mult4_dot_s1 u_s1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .acpt    (accept),
      .a_in    (in_a),
      .b_in    (in_b),
      .last_in (in_last),
      .s1_vld  (s1_vld),
      .s1_last (s1_last),
      .prod    (prod)
   );

   always_comb begin
      add_val = s1_vld ? ACC_W'(prod) : '0;
      acc_sum = {1'b0, acc_q} + {1'b0, add_val};
      cnt_inc = cnt_q + ONE;
      // Elements already taken in this vector: absorbed by S2 plus the one sitting in S1.
      pend    = cnt_q + (LEN_W+1)'(s1_vld);
      closing = in_last | (pend == LIMIT - ONE);

      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      trunc_d   = trunc_q;
      res_d     = res_q;
      out_vld_d = out_vld_q;

      // S2: fold in whatever S1 holds this cycle.
      if (s1_vld) begin
         acc_d = acc_sum[ACC_W-1:0];
         cnt_d = cnt_inc;
         ovf_d = ovf_q | acc_sum[ACC_W];
         // in_last on the limit element wins: not a truncation.
         if (!s1_last && (cnt_inc == LIMIT)) begin
            trunc_d = 1'b1;
         end
      end

      unique case (state_q)
         ACC: begin
            if (accept && closing) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // First DRAIN cycle absorbs the closing product; once S1 is empty the totals are final.
            if (!s1_vld) begin
               res_d     = '{sum: acc_d, len: cnt_d, ovf: ovf_d, trunc: trunc_d};
               out_vld_d = 1'b1;
               state_d   = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_vld_d = 1'b0;
               acc_d     = '0;
               cnt_d     = '0;
               ovf_d     = 1'b0;
               trunc_d   = 1'b0;
               state_d   = ACC;
            end
         end
         default: begin
            state_d = ACC;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ACC;
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         trunc_q   <= 1'b0;
         res_q     <= '0;
         out_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         trunc_q   <= trunc_d;
         res_q     <= res_d;
         out_vld_q <= out_vld_d;
      end
   end

   assign out_valid = out_vld_q;
   assign out_sum   = res_q.sum;
   assign out_len   = res_q.len;
   assign out_ovf   = res_q.ovf;
   assign out_trunc = res_q.trunc;

endmodule
